// File: rtl/motor_ctrl_pkg.sv
// Shared types for the multi-channel H-bridge controller: channel states,
// command encodings and the state-to-gate-drive mapping.
package motor_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FWD,
    ST_REV,
    ST_DEAD,
    ST_FAULT
  } state_t;

  localparam logic [1:0] CMD_OFF = 2'b00;
  localparam logic [1:0] CMD_FWD = 2'b01;
  localparam logic [1:0] CMD_REV = 2'b10;
  localparam logic [1:0] CMD_ILL = 2'b11;

  // Only the two drive states energise the bridge; everything else is all-off.
  function automatic logic [1:0] drive(input state_t s);
    case (s)
      ST_FWD:  drive = CMD_FWD;
      ST_REV:  drive = CMD_REV;
      default: drive = CMD_OFF;
    endcase
  endfunction

endpackage

// File: rtl/motor_channel.sv
// One H-bridge channel: direction FSM with dead-time counter.
// Fault latching on command 11 is built only with MOTOR_CTRL_FAULT_LATCH_EN.
module motor_channel
  import motor_ctrl_pkg::*;
#(
  parameter int unsigned DEAD_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] sel,
  input  logic       clear_fault,
  output logic [1:0] sel_protected,
  output logic       busy,
  output logic       fault
);

  localparam int unsigned    CW        = $clog2(DEAD_CYCLES + 1);
  localparam logic [CW-1:0] DEAD_LOAD = CW'(DEAD_CYCLES - 1);

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [1:0]    cmd;

`ifdef MOTOR_CTRL_FAULT_LATCH_EN
  assign cmd = sel;
`else
  logic unused_clear_fault;
  assign cmd                = (sel == CMD_ILL) ? CMD_OFF : sel;
  assign unused_clear_fault = clear_fault;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      ST_IDLE: begin
        if (cmd == CMD_FWD)      state_nxt = ST_FWD;
        else if (cmd == CMD_REV) state_nxt = ST_REV;
      end
      ST_FWD, ST_REV: begin
        if (cmd != drive(state)) begin
          state_nxt = ST_DEAD;
          cnt_nxt   = DEAD_LOAD;
        end
      end
      ST_DEAD: begin
        // Counter sits at 0 on the final dead cycle, so it already holds 0 on exit.
        if (cnt == '0) begin
          if (cmd == CMD_FWD)      state_nxt = ST_FWD;
          else if (cmd == CMD_REV) state_nxt = ST_REV;
          else                     state_nxt = ST_IDLE;
        end else begin
          cnt_nxt = cnt - CW'(1);
        end
      end
`ifdef MOTOR_CTRL_FAULT_LATCH_EN
      ST_FAULT: begin
        if (clear_fault) begin
          state_nxt = ST_DEAD;
          cnt_nxt   = DEAD_LOAD;
        end
      end
`endif
      default: begin
        state_nxt = ST_IDLE;
        cnt_nxt   = '0;
      end
    endcase
`ifdef MOTOR_CTRL_FAULT_LATCH_EN
    // Illegal command wins over everything, including a clear at the same edge.
    if (cmd == CMD_ILL) begin
      state_nxt = ST_FAULT;
      cnt_nxt   = '0;
    end
`endif
  end

  assign sel_protected = drive(state);
  assign busy          = (state == ST_DEAD);
`ifdef MOTOR_CTRL_FAULT_LATCH_EN
  assign fault = (state == ST_FAULT);
`else
  assign fault = 1'b0;
`endif

endmodule

// File: rtl/multi_motor_controller.sv
// N-channel H-bridge direction controller with per-channel dead-time.
// Optional fault latching is enabled with MOTOR_CTRL_FAULT_LATCH_EN.
module multi_motor_controller
  import motor_ctrl_pkg::*;
#(
  parameter int unsigned N_MOTORS    = 4,
  parameter int unsigned DEAD_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [2*N_MOTORS-1:0] sel,
  input  logic [N_MOTORS-1:0]   clear_fault,
  output logic [2*N_MOTORS-1:0] sel_protected,
  output logic [N_MOTORS-1:0]   busy,
  output logic [N_MOTORS-1:0]   fault
);

  for (genvar i = 0; i < N_MOTORS; i++) begin : g_ch
    motor_channel #(
      .DEAD_CYCLES(DEAD_CYCLES)
    ) u_ch (
      .clk           (clk),
      .rst           (rst),
      .sel           (sel[2*i +: 2]),
      .clear_fault   (clear_fault[i]),
      .sel_protected (sel_protected[2*i +: 2]),
      .busy          (busy[i]),
      .fault         (fault[i])
    );
  end

endmodule

// File: tb/tb_multi_motor_controller.sv
// Self-checking bench for multi_motor_controller (6 channels, 16 dead cycles);
// fault scenarios adapt to whether MOTOR_CTRL_FAULT_LATCH_EN is defined.
module tb_multi_motor_controller;

  localparam int N = 6;
  localparam int D = 16;

  logic           clk = 1'b0;
  logic           rst;
  logic [2*N-1:0] sel;
  logic [N-1:0]   clear_fault;
  logic [2*N-1:0] sel_protected;
  logic [N-1:0]   busy;
  logic [N-1:0]   fault;

  multi_motor_controller #(
    .N_MOTORS    (N),
    .DEAD_CYCLES (D)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .sel           (sel),
    .clear_fault   (clear_fault),
    .sel_protected (sel_protected),
    .busy          (busy),
    .fault         (fault)
  );

  always #5 clk = ~clk;

`ifdef MOTOR_CTRL_FAULT_LATCH_EN
  localparam bit LATCH = 1'b1;
`else
  localparam bit LATCH = 1'b0;
`endif

  int checks   = 0;
  int failures = 0;

  // Reference model: current drive, absolute edge index at which dead-time ends, fault flag.
  int      t = 0;
  int      m_drv[N];
  bit      m_dead[N];
  int      m_dead_end[N];
  bit      m_flt[N];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int cmd_of(input int ch);
    logic [2*N-1:0] v;
    v = sel;
    return int'(v[2*ch +: 2]);
  endfunction

  task automatic model_edge();
    for (int ch = 0; ch < N; ch++) begin
      int c;
      c = cmd_of(ch);
      if (!LATCH && c == 3) c = 0;
      if (rst) begin
        m_drv[ch] = 0; m_dead[ch] = 0; m_flt[ch] = 0;
      end else if (LATCH && c == 3) begin
        m_drv[ch] = 0; m_dead[ch] = 0; m_flt[ch] = 1;
      end else if (m_flt[ch]) begin
        if (clear_fault[ch]) begin
          m_flt[ch] = 0; m_dead[ch] = 1; m_dead_end[ch] = t + D;
        end
      end else if (m_dead[ch]) begin
        if (t == m_dead_end[ch]) begin
          m_dead[ch] = 0;
          m_drv[ch]  = (c == 1 || c == 2) ? c : 0;
        end
      end else if (m_drv[ch] == 0) begin
        m_drv[ch] = (c == 1 || c == 2) ? c : 0;
      end else if (c != m_drv[ch]) begin
        m_drv[ch] = 0; m_dead[ch] = 1; m_dead_end[ch] = t + D;
      end
    end
  endtask

  task automatic step();
    logic [2*N-1:0] e_sel;
    logic [N-1:0]   e_busy, e_flt;
    @(posedge clk);
    t++;
    model_edge();
    #1;
    for (int ch = 0; ch < N; ch++) begin
      e_sel[2*ch +: 2] = 2'(m_drv[ch]);
      e_busy[ch]       = m_dead[ch];
      e_flt[ch]        = m_flt[ch];
    end
    check("sel_protected", 32'(sel_protected), 32'(e_sel));
    check("busy", 32'(busy), 32'(e_busy));
    check("fault", 32'(fault), 32'(e_flt));
  endtask

  task automatic set_cmd(input int ch, input logic [1:0] v);
    sel[2*ch +: 2] = v;
  endtask

  // Steps until the channel drives again; returns the number of all-off cycles seen.
  task automatic count_off(input int ch, output int n);
    logic [2*N-1:0] v;
    n = 0;
    for (int k = 0; k < 3 * D; k++) begin
      step();
      v = sel_protected;
      if (v[2*ch +: 2] != 2'b00) break;
      n++;
    end
  endtask

  initial begin
    int n;
    logic [2*N-1:0] v;
    for (int ch = 0; ch < N; ch++) begin
      m_drv[ch] = 0; m_dead[ch] = 0; m_dead_end[ch] = 0; m_flt[ch] = 0;
    end
    rst = 1'b1; sel = {N{2'b01}}; clear_fault = '0;
    #2;
    step();
    check("reset_sel_zero", 32'(sel_protected), 32'h0);
    step();
    rst = 1'b0;
    step();
    check("first_drive_ch0", 32'(sel_protected[1:0]), 32'h1);
    repeat (3) step();

    // Straight reversal on channel 0.
    set_cmd(0, 2'b10);
    count_off(0, n);
    check("reversal_off_cycles", 32'(n), 32'(D));
    check("reversal_new_dir", 32'(sel_protected[1:0]), 32'h2);

    // Sneak reversal on channel 1: one cycle of off, then reverse.
    set_cmd(1, 2'b00);
    step();
    set_cmd(1, 2'b10);
    count_off(1, n);
    check("sneak_off_cycles", 32'(n + 1), 32'(D));

    // FWD -> off -> FWD still pays dead-time.
    set_cmd(3, 2'b00);
    step();
    set_cmd(3, 2'b01);
    count_off(3, n);
    check("refwd_off_cycles", 32'(n + 1), 32'(D));

    // Channel 5 reversals while channel 0 holds REV.
    for (int r = 0; r < 3; r++) begin
      set_cmd(5, (r % 2 == 0) ? 2'b10 : 2'b01);
      for (int k = 0; k < D + 2; k++) begin
        step();
        v = sel_protected;
        check("ch0_hold_rev", 32'(v[1:0]), 32'h2);
      end
    end

    // Command 11 on channel 2 from FWD.
    set_cmd(2, 2'b11);
    step();
    check("ill_ch2_fault", 32'(fault[2]), 32'(LATCH));
    repeat (3) step();
    clear_fault[2] = 1'b1;
    step();
    check("clear_with_ill", 32'(fault[2]), 32'(LATCH));
    set_cmd(2, 2'b01);
    step();
    clear_fault[2] = 1'b0;
    repeat (D + 2) step();
    check("ch2_after_clear", 32'(sel_protected[5:4]), 32'h1);

    // Reset mid-dead-time, then immediate drive.
    set_cmd(4, 2'b10);
    repeat (5) step();
    rst = 1'b1;
    step();
    check("rst_mid_dead_busy", 32'(busy), 32'h0);
    rst = 1'b0;
    step();
    check("drive_after_rst", 32'(sel_protected[9:8]), 32'h2);

    // Randomized traffic with occasional clears and rare resets.
    for (int k = 0; k < 3000; k++) begin
      for (int ch = 0; ch < N; ch++)
        if ($urandom_range(0, 9) == 0) set_cmd(ch, 2'($urandom_range(0, 3)));
      for (int ch = 0; ch < N; ch++)
        clear_fault[ch] = ($urandom_range(0, 7) == 0);
      rst = ($urandom_range(0, 299) == 0);
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
